mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameters, one per line: NB_data, 32, datapath width; NB_addr, 5, register-index width; NB_depth, 8, log2 of data-memory depth in words (256 words).
REQ-002 The block SHALL use one clock, clk, and a synchronous, active-high reset, reset.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock, rising edge.
- reset, in, 1, synchronous active-high reset.
- in_mem, in, 3, memory control: [2] mem_write, [1] mem_read, [0] unsigned load.
- in_mem_size, in, 2, access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- in_wb, in, 2, writeback control: [1] reg_write, [0] mem_to_reg.
- in_alu, in, NB_data, ALU result and byte address.
- in_w_data, in, NB_data, store data.
- in_reg_dest, in, NB_addr, destination register.
- in_stall, in, 1, hold the stage.
- out_reg_write, out, 1, register-file write enable to ID.
- out_wdata, out, NB_data, writeback data to ID.
- out_rd, out, NB_addr, writeback register index to ID.
- out_misalign, out, 1, misaligned-access flag (registered).

Function
REQ-004 The EX/MEM inputs SHALL be consumed at rising edge k; the MEM/WB outputs SHALL be valid after edge k. Latency is 1 cycle.
REQ-005 Word index SHALL be in_alu[NB_depth+1:2]. Higher address bits are ignored, so addresses wrap modulo 1 KiB.
REQ-006 Stores SHALL be little-endian:
- byte: writes in_w_data[7:0] to lane in_alu[1:0].
- half: writes in_w_data[15:0] to lanes selected by in_alu[1].
- word: writes all 4 lanes.
- All other lanes SHALL be preserved.
REQ-007 Loads SHALL extract the same lane or lanes. They SHALL sign-extend when in_mem[0]=0 and zero-extend when in_mem[0]=1.
REQ-008 Memory reads SHALL be synchronous. A store at edge k followed by a load of the same address at edge k+1 SHALL return the stored data.
REQ-009 If mem_read and mem_write are both 1, the store SHALL take effect and the load result SHALL be the pre-store data.
REQ-010 out_wdata SHALL equal the loaded data when mem_to_reg=1, otherwise the registered in_alu.
REQ-011 out_reg_write SHALL be the registered reg_write, forced to 0 when out_rd=0.
REQ-012 When in_stall=1:
- No store SHALL be performed.
- The MEM/WB register SHALL hold its value.
- out_reg_write SHALL be 0 for that cycle.

Reset
REQ-013 On reset at a rising edge, the block SHALL set out_reg_write=0, out_wdata=0, out_rd=0 and out_misalign=0, and SHALL perform no store that cycle.
REQ-014 Reset SHALL take priority over in_stall. A store presented in the same cycle as reset SHALL be dropped.
REQ-015 Memory contents SHALL NOT be reset and are undefined until written.

Configuration
REQ-016 The macro MEM_MISALIGN_TRAP_EN SHALL select misaligned-access handling.
- Defined: a half access with in_alu[0]=1, or a word access with in_alu[1:0]≠0, SHALL suppress the store and suppress out_reg_write, and SHALL assert out_misalign for exactly one cycle.
- Undefined: the low address bits below the access size SHALL be ignored (forced aligned), and out_misalign SHALL be tied to 0.

Structure
REQ-017 A shared package SHALL hold the following, for reuse by ID and EX:
- in_mem bit positions.
- in_wb bit positions.
- size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD).
- NB_data and NB_addr defaults.
REQ-018 One sub-module, data_mem, SHALL be instantiated: a byte-lane-enabled synchronous RAM. Lane alignment and extension logic SHALL stay in mem_wb_stage.

Verification
REQ-019 Word store then load: SW 0xDEADBEEF at address 0x10, then LW from 0x10 into rd=3 → out_wdata=0xDEADBEEF, out_rd=3, out_reg_write=1 one cycle after the LW.
REQ-020 Byte loads: after the word above, LB from 0x13 → 0xFFFFFFDE; LBU from 0x13 → 0x000000DE; LH from 0x10 → 0xFFFFBEEF.
REQ-021 ALU writeback and r0 suppression: in_wb=10, in_alu=0x1234, rd=5 → out_wdata=0x1234, out_reg_write=1; same with rd=0 → out_reg_write=0.
REQ-022 Stall and reset: SB 0x55 at 0x20 with in_stall=1 → the word at 0x20 is unchanged; assert reset mid-stream → all outputs 0 on the next edge.
REQ-023 Address wrap: SW 0xA5A5A5A5 at 0x400, then LW from 0x000 → 0xA5A5A5A5.
REQ-024 Misaligned access with MEM_MISALIGN_TRAP_EN defined: LW from 0x11 → out_misalign=1 for one cycle and out_reg_write=0. Without the macro: the same LW returns the word at 0x10.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage_pkg
// Description : Shared control-field positions, access-size encodings and
//               datapath width defaults for the ID/EX/MEM pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_stage_pkg;

    localparam int NB_DATA_DEFAULT = 32;
    localparam int NB_ADDR_DEFAULT = 5;

    localparam int MEM_WRITE_BIT    = 2;
    localparam int MEM_READ_BIT     = 1;
    localparam int MEM_UNSIGNED_BIT = 0;

    localparam int WB_REG_WRITE_BIT  = 1;
    localparam int WB_MEM_TO_REG_BIT = 0;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_data_mem.sv
`default_nettype none
// ============================================================================
// Module      : data_mem
// Description : Byte-lane-enabled single-port RAM with a registered read
//               port; reads return the contents from before a same-edge write.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem #(
    parameter int NB_data  = 32,
    parameter int NB_depth = 8
) (
    input  wire logic                   clk_i,
    input  wire logic                   re_i,
    input  wire logic [NB_data/8-1:0]   be_i,
    input  wire logic [NB_depth-1:0]    addr_i,
    input  wire logic [NB_data-1:0]     wdata_i,
    output logic      [NB_data-1:0]     rdata_o
);
    localparam int NB_LANES = NB_data / 8;

    logic [NB_data-1:0] mem_q [2**NB_depth];
    logic [NB_data-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NB_LANES; i++) begin
            if (be_i[i]) begin
                mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM stage and MEM/WB register: lane-aligned stores/loads with
//               sign/zero extension and writeback select.
//               Optional macro MEM_MISALIGN_TRAP_EN traps misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int NB_data  = NB_DATA_DEFAULT,
    parameter int NB_addr  = NB_ADDR_DEFAULT,
    parameter int NB_depth = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [2:0]         in_mem,
    input  wire logic [1:0]         in_mem_size,
    input  wire logic [1:0]         in_wb,
    input  wire logic [NB_data-1:0] in_alu,
    input  wire logic [NB_data-1:0] in_w_data,
    input  wire logic [NB_addr-1:0] in_reg_dest,
    input  wire logic               in_stall,
    output logic                    out_reg_write,
    output logic      [NB_data-1:0] out_wdata,
    output logic      [NB_addr-1:0] out_rd,
    output logic                    out_misalign
);
    localparam int NB_LANES = NB_data / 8;

    logic                w_is_byte;
    logic                w_is_half;
    logic                w_trap;
    logic                w_store_en;
    logic                w_read_en;
    logic [1:0]          w_lane;
    logic [NB_LANES-1:0] w_be;
    logic [NB_data-1:0]  w_store_data;
    logic [NB_data-1:0]  w_rdata;
    logic [NB_data-1:0]  w_load_data;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [NB_depth-1:0] w_word_idx;

    logic                reg_write_d;
    logic                reg_write_q;
    logic                mem_to_reg_q;
    logic                unsigned_q;
    logic [1:0]          size_q;
    logic [1:0]          lane_q;
    logic [NB_data-1:0]  alu_q;
    logic [NB_addr-1:0]  rd_q;

    assign w_is_byte  = (in_mem_size == SIZE_BYTE);
    assign w_is_half  = (in_mem_size == SIZE_HALF);
    assign w_word_idx = in_alu[NB_depth+1:2];
    // Low address bits below the access size are dropped, which forces alignment.
    assign w_lane     = w_is_byte ? in_alu[1:0] :
                        w_is_half ? {in_alu[1], 1'b0} : 2'b00;

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_access;
    logic misalign_q;

    assign w_access = in_mem[MEM_WRITE_BIT] | in_mem[MEM_READ_BIT];
    assign w_trap   = w_access &
                      ((w_is_half & in_alu[0]) |
                       (!w_is_byte && !w_is_half && (in_alu[1:0] != 2'b00)));

    always_ff @(posedge clk) begin
        if (reset || in_stall) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= w_trap;
        end
    end

    assign out_misalign = misalign_q;
`else
    assign w_trap       = 1'b0;
    assign out_misalign = 1'b0;
`endif

    assign w_store_en = in_mem[MEM_WRITE_BIT] & ~in_stall & ~reset & ~w_trap;
    assign w_read_en  = ~in_stall;

    always_comb begin
        w_be         = '1;
        w_store_data = in_w_data;
        if (w_is_byte) begin
            w_be         = NB_LANES'(1) << w_lane;
            w_store_data = {NB_LANES{in_w_data[7:0]}};
        end else if (w_is_half) begin
            w_be         = NB_LANES'(3) << w_lane;
            w_store_data = {(NB_LANES/2){in_w_data[15:0]}};
        end
        if (!w_store_en) begin
            w_be = '0;
        end
    end

    data_mem #(
        .NB_data  (NB_data),
        .NB_depth (NB_depth)
    ) u_data_mem (
        .clk_i   (clk),
        .re_i    (w_read_en),
        .be_i    (w_be),
        .addr_i  (w_word_idx),
        .wdata_i (w_store_data),
        .rdata_o (w_rdata)
    );

    assign reg_write_d = in_wb[WB_REG_WRITE_BIT] & ~w_trap;

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            unsigned_q   <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            alu_q        <= '0;
            rd_q         <= '0;
        end else if (in_stall) begin
            reg_write_q  <= 1'b0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= in_wb[WB_MEM_TO_REG_BIT];
            unsigned_q   <= in_mem[MEM_UNSIGNED_BIT];
            size_q       <= in_mem_size;
            lane_q       <= w_lane;
            alu_q        <= in_alu;
            rd_q         <= in_reg_dest;
        end
    end

    // Lane extraction uses the captured address/size, aligned with the registered RAM output.
    always_comb begin
        w_byte      = w_rdata[{lane_q, 3'b000} +: 8];
        w_half      = w_rdata[{lane_q[1], 4'b0000} +: 16];
        w_load_data = w_rdata;
        if (size_q == SIZE_BYTE) begin
            w_load_data = {{(NB_data-8){~unsigned_q & w_byte[7]}}, w_byte};
        end else if (size_q == SIZE_HALF) begin
            w_load_data = {{(NB_data-16){~unsigned_q & w_half[15]}}, w_half};
        end
    end

    assign out_wdata     = mem_to_reg_q ? w_load_data : alu_q;
    assign out_rd        = rd_q;
    assign out_reg_write = reg_write_q & (rd_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Directed scoreboard bench for mem_wb_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  in_mem;
    logic [1:0]  in_mem_size;
    logic [1:0]  in_wb;
    logic [31:0] in_alu;
    logic [31:0] in_w_data;
    logic [4:0]  in_reg_dest;
    logic        in_stall;
    logic        out_reg_write;
    logic [31:0] out_wdata;
    logic [4:0]  out_rd;
    logic        out_misalign;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic        rw;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        mis;
        logic        chk_wd;
    } exp_t;

    exp_t sb_q[$];

    mem_wb_stage #(
        .NB_data  (32),
        .NB_addr  (5),
        .NB_depth (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_mem        (in_mem),
        .in_mem_size   (in_mem_size),
        .in_wb         (in_wb),
        .in_alu        (in_alu),
        .in_w_data     (in_w_data),
        .in_reg_dest   (in_reg_dest),
        .in_stall      (in_stall),
        .out_reg_write (out_reg_write),
        .out_wdata     (out_wdata),
        .out_rd        (out_rd),
        .out_misalign  (out_misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard: got output with empty queue, expected an entry");
            return;
        end
        e = sb_q.pop_front();
        n_cmp++;
        assert (out_reg_write === e.rw) else begin
            n_fail++;
            $error("FAIL %s reg_write: got %0b expected %0b", e.tag, out_reg_write, e.rw);
        end
        n_cmp++;
        assert (out_rd === e.rd) else begin
            n_fail++;
            $error("FAIL %s rd: got %0d expected %0d", e.tag, out_rd, e.rd);
        end
        n_cmp++;
        assert (out_misalign === e.mis) else begin
            n_fail++;
            $error("FAIL %s misalign: got %0b expected %0b", e.tag, out_misalign, e.mis);
        end
        if (e.chk_wd) begin
            n_cmp++;
            assert (out_wdata === e.wd) else begin
                n_fail++;
                $error("FAIL %s wdata: got %h expected %h", e.tag, out_wdata, e.wd);
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic st,
                        input logic [2:0] m, input logic [1:0] sz, input logic [1:0] wb,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                        input logic e_rw, input logic [31:0] e_wd, input logic [4:0] e_rd,
                        input logic e_mis, input logic chk_wd);
        exp_t e;
        reset       = r;
        in_stall    = st;
        in_mem      = m;
        in_mem_size = sz;
        in_wb       = wb;
        in_alu      = a;
        in_w_data   = d;
        in_reg_dest = rd;
        e.tag    = tag;
        e.rw     = e_rw;
        e.wd     = e_wd;
        e.rd     = e_rd;
        e.mis    = e_mis;
        e.chk_wd = chk_wd;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // mem: 100 store, 010 signed load, 011 unsigned load, 110 store+load
    // size: 00 byte, 01 half, 10 word; wb: 11 load writeback, 10 ALU writeback
    initial begin
        step("reset",      1, 0, 3'b000, 2'b10, 2'b00, 32'h0,   32'h0,        5'd0, 0, 32'h0,        5'd0, 0, 1);
        step("sw_10",      0, 0, 3'b100, 2'b10, 2'b00, 32'h10,  32'hDEADBEEF, 5'd0, 0, 32'h10,       5'd0, 0, 1);
        step("lw_10",      0, 0, 3'b010, 2'b10, 2'b11, 32'h10,  32'h0,        5'd3, 1, 32'hDEADBEEF, 5'd3, 0, 1);
        step("lb_13",      0, 0, 3'b010, 2'b00, 2'b11, 32'h13,  32'h0,        5'd4, 1, 32'hFFFFFFDE, 5'd4, 0, 1);
        step("lbu_13",     0, 0, 3'b011, 2'b00, 2'b11, 32'h13,  32'h0,        5'd4, 1, 32'h000000DE, 5'd4, 0, 1);
        step("lh_10",      0, 0, 3'b010, 2'b01, 2'b11, 32'h10,  32'h0,        5'd6, 1, 32'hFFFFBEEF, 5'd6, 0, 1);
        step("lhu_12",     0, 0, 3'b011, 2'b01, 2'b11, 32'h12,  32'h0,        5'd6, 1, 32'h0000DEAD, 5'd6, 0, 1);
        step("alu_rd5",    0, 0, 3'b000, 2'b10, 2'b10, 32'h1234, 32'h0,       5'd5, 1, 32'h1234,     5'd5, 0, 1);
        step("alu_rd0",    0, 0, 3'b000, 2'b10, 2'b10, 32'h1234, 32'h0,       5'd0, 0, 32'h1234,     5'd0, 0, 1);
        step("sw_20",      0, 0, 3'b100, 2'b10, 2'b00, 32'h20,  32'h0,        5'd0, 0, 32'h20,       5'd0, 0, 1);
        step("alu_rd9",    0, 0, 3'b000, 2'b10, 2'b10, 32'hABCD, 32'h0,       5'd9, 1, 32'hABCD,     5'd9, 0, 1);
        step("stall_sb",   0, 1, 3'b100, 2'b00, 2'b10, 32'h20,  32'h55,       5'd7, 0, 32'hABCD,     5'd9, 0, 1);
        step("lw_20",      0, 0, 3'b010, 2'b10, 2'b11, 32'h20,  32'h0,        5'd8, 1, 32'h0,        5'd8, 0, 1);
        step("sw_lw_20",   0, 0, 3'b110, 2'b10, 2'b11, 32'h20,  32'h12345678, 5'd8, 1, 32'h0,        5'd8, 0, 1);
        step("lw_20_new",  0, 0, 3'b010, 2'b10, 2'b11, 32'h20,  32'h0,        5'd8, 1, 32'h12345678, 5'd8, 0, 1);
        step("sb_21",      0, 0, 3'b100, 2'b00, 2'b00, 32'h21,  32'hFFFFFF99, 5'd0, 0, 32'h21,       5'd0, 0, 1);
        step("lw_20_sb",   0, 0, 3'b010, 2'b10, 2'b11, 32'h20,  32'h0,        5'd8, 1, 32'h12349978, 5'd8, 0, 1);
        step("sh_22",      0, 0, 3'b100, 2'b01, 2'b00, 32'h22,  32'h1111CAFE, 5'd0, 0, 32'h22,       5'd0, 0, 1);
        step("lw_20_sh",   0, 0, 3'b010, 2'b10, 2'b11, 32'h20,  32'h0,        5'd8, 1, 32'hCAFE9978, 5'd8, 0, 1);
        step("sw_30",      0, 0, 3'b100, 2'b10, 2'b00, 32'h30,  32'h77777777, 5'd0, 0, 32'h30,       5'd0, 0, 1);
        step("reset_mid",  1, 1, 3'b100, 2'b10, 2'b11, 32'h30,  32'h11111111, 5'd3, 0, 32'h0,        5'd0, 0, 1);
        step("lw_30",      0, 0, 3'b010, 2'b10, 2'b11, 32'h30,  32'h0,        5'd2, 1, 32'h77777777, 5'd2, 0, 1);
        step("sw_400",     0, 0, 3'b100, 2'b10, 2'b00, 32'h400, 32'hA5A5A5A5, 5'd0, 0, 32'h400,      5'd0, 0, 1);
        step("lw_000",     0, 0, 3'b010, 2'b10, 2'b11, 32'h0,   32'h0,        5'd1, 1, 32'hA5A5A5A5, 5'd1, 0, 1);
`ifdef MEM_MISALIGN_TRAP_EN
        step("lw_11_trap", 0, 0, 3'b010, 2'b10, 2'b11, 32'h11,  32'h0,        5'd10, 0, 32'h0,       5'd10, 1, 0);
`else
        step("lw_11_algn", 0, 0, 3'b010, 2'b10, 2'b11, 32'h11,  32'h0,        5'd10, 1, 32'hDEADBEEF, 5'd10, 0, 1);
`endif
        step("idle",       0, 0, 3'b000, 2'b10, 2'b00, 32'h0,   32'h0,        5'd0, 0, 32'h0,        5'd0, 0, 1);

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard_drain: got %0d pending entries expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
